// File: rtl/imem_arbiter_if.sv
// ============================================================================
// Module      : imem_arbiter_if
// Description : Bundles the fetch and debug req/gnt/rvalid handshakes and the
//               instruction-memory port that meet at imem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_arbiter_if;
  // Fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  // Debug / loader requester
  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  // Instruction memory port
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  // Status
  logic        busy;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wdata, busy
  );

  // Requesters and memory side
  modport master (
    output if_req, if_addr, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata, busy
  );
endinterface

`default_nettype wire

// File: rtl/imem_arbiter.sv
// ============================================================================
// Module      : imem_arbiter
// Description : Shares the instruction-memory port between fetch and a
//               debug/loader requester. Fetch has priority; debug is promoted
//               after STARVE_LIMIT fetch grants while it waits. Each access
//               holds the memory enables for WAIT_CYCLES cycles, then returns
//               the registered word with a one-cycle rvalid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_arbiter #(
  parameter int WAIT_CYCLES  = 1,   // 1..15
  parameter int STARVE_LIMIT = 4    // 1..15
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  imem_arbiter_if.slave  bus
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_access = 2'd1;
  localparam logic [1:0] c_resp   = 2'd2;

  localparam logic [3:0] c_wait_init    = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [3:0]  r_wait_cnt;
  logic [3:0]  r_starve_cnt;
  logic        r_owner_dbg;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dbg_rdata;

  logic        w_grant_window;
  logic        w_dbg_wins;
  logic        w_if_gnt;
  logic        w_dbg_gnt;
  logic        w_last_access;

  // Grants are only possible in IDLE/RESP and never while reset is asserted;
  // debug wins when fetch is silent or fetch has used up its starvation quota.
  assign w_grant_window = rst_n && ((r_state == c_idle) || (r_state == c_resp));
  assign w_dbg_wins     = bus.dbg_req && (!bus.if_req || (r_starve_cnt == c_starve_limit));
  assign w_dbg_gnt      = w_grant_window && w_dbg_wins;
  assign w_if_gnt       = w_grant_window && bus.if_req && !w_dbg_wins;
  assign w_last_access  = (r_state == c_access) && (r_wait_cnt == 4'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle, c_resp: w_next_state = (w_if_gnt || w_dbg_gnt) ? c_access : c_idle;
      c_access:       w_next_state = (r_wait_cnt == 4'd0) ? c_resp : c_access;
      default:        w_next_state = c_idle;
    endcase
  end

  // Output decode: memory enables only in ACCESS, rvalid only in RESP
  always_comb begin
    bus.if_gnt     = w_if_gnt;
    bus.dbg_gnt    = w_dbg_gnt;
    bus.mem_rd_en  = 1'b0;
    bus.mem_wr_en  = 1'b0;
    bus.mem_addr   = 32'd0;
    bus.mem_wdata  = 32'd0;
    bus.busy       = 1'b0;
    bus.if_rvalid  = 1'b0;
    bus.dbg_rvalid = 1'b0;
    bus.if_rdata   = r_if_rdata;
    bus.dbg_rdata  = r_dbg_rdata;
    if (r_state == c_access) begin
      bus.mem_rd_en = !r_we;
      bus.mem_wr_en = r_we;
      bus.mem_addr  = r_addr;
      bus.mem_wdata = r_wdata;
      bus.busy      = 1'b1;
    end
    if (r_state == c_resp) begin
      bus.if_rvalid  = !r_owner_dbg;
      bus.dbg_rvalid = r_owner_dbg;
    end
  end

  // Capture the winning request and run the wait counter through ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_dbg <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_wait_cnt  <= 4'd0;
    end else if (w_dbg_gnt) begin
      r_owner_dbg <= 1'b1;
      r_we        <= bus.dbg_we;
      r_addr      <= bus.dbg_addr;
      r_wdata     <= bus.dbg_wdata;
      r_wait_cnt  <= c_wait_init;
    end else if (w_if_gnt) begin
      r_owner_dbg <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= bus.if_addr;
      r_wdata     <= 32'd0;
      r_wait_cnt  <= c_wait_init;
    end else if ((r_state == c_access) && (r_wait_cnt != 4'd0)) begin
      r_wait_cnt  <= r_wait_cnt - 4'd1;
    end
  end

  // Count fetch grants taken while debug waits; a debug grant resets the quota
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 4'd0;
    end else if (w_dbg_gnt) begin
      r_starve_cnt <= 4'd0;
    end else if (w_if_gnt && bus.dbg_req && (r_starve_cnt != c_starve_limit)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Latch the memory word into the owner's read-data register on the last ACCESS cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rdata  <= 32'd0;
      r_dbg_rdata <= 32'd0;
    end else if (w_last_access) begin
      if (r_owner_dbg) begin
        r_dbg_rdata <= r_we ? 32'd0 : bus.mem_rdata;
      end else begin
        r_if_rdata  <= bus.mem_rdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/imem_arbiter.md
# imem_arbiter

Arbiter and access sequencer that shares the single instruction-memory port between the fetch stage and a debug/loader requester. Each requester gets a req/gnt/rvalid handshake. The block drives the memory's read-enable, write-enable, address and write-data for a programmable number of wait cycles, then returns the registered read word. It sits between the PC/IF logic and the instruction memory, and lets the program image be patched or read back at runtime without stopping the core.

## Interface
- WAIT_CYCLES, 1: memory access cycles per transaction, legal range 1..15.
- STARVE_LIMIT, 4: consecutive fetch grants allowed while dbg_req is pending before debug wins; legal range 1..15.
- clk  in  1  sole clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request (read only).
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  32  fetched instruction.
- dbg_req  in  1  debug/loader request.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  32  debug byte address.
- dbg_wdata  in  32  debug write data.
- dbg_gnt  out  1  debug request accepted this cycle.
- dbg_rvalid  out  1  one-cycle pulse: read data valid, or write done.
- dbg_rdata  out  32  debug read data; 0 for writes.
- mem_rd_en  out  1  memory read enable.
- mem_wr_en  out  1  memory write enable.
- mem_addr  out  32  memory byte address. Memory uses bits [MSB:2].
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, combinational from mem_addr.
- busy  out  1  high in ACCESS state.

## Operation
- FSM has three states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Grants are issued only in IDLE or RESP. They are combinational from the state and the requests. At most one gnt is high per cycle.
- Arbitration:
  - Fetch has priority.
  - Debug wins when only dbg_req is high.
  - Debug also wins when both requests are high and starve_cnt == STARVE_LIMIT.
- starve_cnt (4 bits):
  - Increments on each if_gnt while dbg_req is high, saturating at STARVE_LIMIT.
  - Clears on dbg_gnt.
  - Holds otherwise.
- On a grant edge the block captures the owner (IF or DBG), the address, we and wdata into registers, then moves to ACCESS with wait_cnt = WAIT_CYCLES-1.
- ACCESS:
  - mem_addr and mem_wdata come from the captured registers.
  - mem_rd_en = !we; mem_wr_en = we. Both are 0 outside ACCESS.
  - wait_cnt decrements each cycle.
  - When wait_cnt == 0, the block samples mem_rdata into the owner's rdata register (0 for writes) and moves to RESP.
- RESP:
  - The owner's rvalid is high for exactly one cycle.
  - If a grant is issued in RESP, go to ACCESS. Otherwise go to IDLE.
- rdata registers hold their value until the next response for that owner.
- Requests are not queued. A requester holds req with a stable address until it sees gnt. Deasserting req before gnt cancels the request.
- Address alignment is not checked. Bits [1:0] are passed through unchanged.

## Timing
- Reset (asynchronous, immediate):
  - State returns to IDLE; starve_cnt = 0.
  - All outputs go to 0: if_gnt, dbg_gnt, if_rvalid, dbg_rvalid, if_rdata, dbg_rdata, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, busy.
  - Grants are also forced to 0 while rst_n is low.
- Reset mid-ACCESS aborts the transaction. No rvalid pulse is produced. A write may be partially applied; software rewrites after reset.
- Latency: gnt in cycle T, ACCESS in T+1..T+WAIT_CYCLES, rvalid in T+WAIT_CYCLES+1.
- Back-to-back transactions: the next gnt can coincide with the previous rvalid, giving a throughput of one transaction per WAIT_CYCLES+1 cycles.
- Requests arriving in ACCESS wait. No gnt is issued until the RESP cycle.

## Test plan
- Single fetch, WAIT_CYCLES=1, memory word 0x10 = 0x00500093:
  - Stimulus: if_req with if_addr=0x10 at cycle 0.
  - Required: if_gnt at cycle 0, mem_rd_en=1 with mem_addr=0x10 at cycle 1, if_rvalid=1 with if_rdata=0x00500093 at cycle 2.
- Debug write then read, WAIT_CYCLES=3:
  - Stimulus: write 0xDEADBEEF to 0x40, then read 0x40.
  - Required: mem_wr_en high for exactly 3 cycles; write dbg_rvalid with dbg_rdata=0; read returns 0xDEADBEEF 4 cycles after its gnt.
- Contention, STARVE_LIMIT=4, both requests held high:
  - Required: grant order IF, IF, IF, IF, DBG, IF…; starve_cnt returns to 0 after the DBG grant.
- Continuous if_req, WAIT_CYCLES=2:
  - Required: grants every 3 cycles; each if_rvalid coincides with the next if_gnt; busy is low only in RESP cycles.
- Reset mid-access:
  - Stimulus: rst_n low during the second ACCESS cycle of a debug write.
  - Required: outputs read 0 before the next clock edge; no rvalid; FSM back in IDLE; the next if_req is granted in its first cycle after reset release.
- Cancel:
  - Stimulus: dbg_req pulses high for 1 cycle during ACCESS, then drops.
  - Required: no dbg_gnt, no dbg_rvalid, and no debug memory cycle at any point.
